// File: rtl/gift_sp_ise.sv
// gift_sp_ise -- forward GIFT-128 round-core ISE (S-box on load, PermBits,
// byte-serial unload). Encrypt-side partner of the inverse permute/S-box ISE.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     one-cycle pulse per ISE instruction
//   a, b      load operands: even / odd state byte of the current pair
//   sr        core status register in
//   sr_out    status register out
//   result    current unload byte (combinational from registers)
//   wait_req  stall request to the core
//
// Parameter UNLOAD_MSB_FIRST: 1 = unload byte 15..0, 0 = byte 0..15.
// Optional macro GIFT_SP_STATUS_EN: sr_out = {sr[7:1], busy}, where busy is
// high everywhere except LOAD with idx = 0 (flags an abandoned partial load).

module gift_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  always_comb begin
    y = 4'h0;
    case (x)
      4'h0: y = 4'h1;  4'h1: y = 4'hA;  4'h2: y = 4'h4;  4'h3: y = 4'hC;
      4'h4: y = 4'h6;  4'h5: y = 4'hF;  4'h6: y = 4'h3;  4'h7: y = 4'h9;
      4'h8: y = 4'h2;  4'h9: y = 4'hD;  4'hA: y = 4'hB;  4'hB: y = 4'h7;
      4'hC: y = 4'h5;  4'hD: y = 4'h0;  4'hE: y = 4'h8;  4'hF: y = 4'hE;
      default: y = 4'h0;
    endcase
  end
endmodule

module gift_sp_ise #(
  parameter bit UNLOAD_MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] sr,
  output logic [7:0] sr_out,
  output logic [7:0] result,
  output logic       wait_req
);

  typedef enum logic [1:0] {ST_LOAD, ST_PERM, ST_UNLOAD} state_e;

  localparam logic [3:0] IDX_FIRST = UNLOAD_MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] IDX_LAST  = UNLOAD_MSB_FIRST ? 4'd0  : 4'd15;

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [127:0]   load_q, load_d;
  logic [127:0]   out_q, out_d;

  logic [15:0]    ab_raw, ab_sub;
  logic [127:0]   perm_w;
  logic [6:0]     pair_sel;
  logic [6:0]     byte_sel;

  // One S-box per nibble of the incoming pair; b lands in the odd byte.
  assign ab_raw = {b, a};
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    gift_sbox u_sbox (.x(ab_raw[4*g +: 4]), .y(ab_sub[4*g +: 4]));
  end

  // PermBits is pure wiring: bit i of the loaded state goes to P(i).
  for (genvar i = 0; i < 128; i++) begin : g_perm
    localparam int P = 4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
    assign perm_w[P] = load_q[i];
  end

  assign pair_sel = {idx_q[2:0], 4'b0000};
  assign byte_sel = {idx_q, 3'b000};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load_d   = load_q;
    out_d    = out_q;
    wait_req = 1'b0;
    result   = out_q[7:0];
    case (state_q)
      ST_LOAD: begin
        if (start) begin
          load_d[pair_sel +: 16] = ab_sub;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd7) begin
            // Final load stalls through this cycle and the PERM cycle.
            wait_req = 1'b1;
            state_d  = ST_PERM;
            idx_d    = 4'd0;
          end
        end
      end
      ST_PERM: begin
        wait_req = 1'b1;
        out_d    = perm_w;
        state_d  = ST_UNLOAD;
        idx_d    = IDX_FIRST;
      end
      ST_UNLOAD: begin
        result = out_q[byte_sel +: 8];
        if (start) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_LOAD;
            idx_d   = 4'd0;
          end else if (UNLOAD_MSB_FIRST) begin
            idx_d = idx_q - 4'd1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= 4'd0;
      load_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      load_q  <= load_d;
      out_q   <= out_d;
    end
  end

`ifdef GIFT_SP_STATUS_EN
  logic busy;
  assign busy   = !((state_q == ST_LOAD) && (idx_q == 4'd0));
  assign sr_out = {sr[7:1], busy};
`else
  assign sr_out = sr;
`endif

endmodule

// File: tb/tb_gift_sp_ise.sv
// Directed bench for gift_sp_ise. Two instances share all inputs: one unloads
// MSB-first, the other LSB-first, so both orders are checked on every vector.
module tb_gift_sp_ise;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic [7:0] sr = 8'hA4;
  logic [7:0] sr_out_m, result_m, sr_out_l, result_l;
  logic       wait_req_m, wait_req_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gift_sp_ise #(.UNLOAD_MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sr(sr),
    .sr_out(sr_out_m), .result(result_m), .wait_req(wait_req_m));

  gift_sp_ise #(.UNLOAD_MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sr(sr),
    .sr_out(sr_out_l), .result(result_l), .wait_req(wait_req_l));

  typedef struct {
    string        name;
    logic [127:0] state_in;   // byte j = state_in[8j +: 8]
    logic [127:0] exp_out;    // byte j of the permuted result
    bit           hold_perm;  // keep start high through the PERM cycle
  } vec_t;

  vec_t vecs[4];

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_sr(input bit busy);
`ifdef GIFT_SP_STATUS_EN
    return {8'hA4 | {7'b0, busy}};
`else
    return 8'hA4;
`endif
  endfunction

  task automatic check_sr(input string nm, input bit busy);
    chk8({nm, " sr_m"}, sr_out_m, exp_sr(busy));
    chk8({nm, " sr_l"}, sr_out_l, exp_sr(busy));
  endtask

  // Inputs change on negedge; outputs are checked #1 later, well before posedge.
  task automatic run_vec(input vec_t v);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b1;
      a = v.state_in[16*k +: 8];
      b = v.state_in[16*k+8 +: 8];
      #1;
      chk1($sformatf("%s load%0d wait_m", v.name, k), wait_req_m, k == 7);
      chk1($sformatf("%s load%0d wait_l", v.name, k), wait_req_l, k == 7);
      check_sr($sformatf("%s load%0d", v.name, k), k != 0);
    end
    // PERM cycle
    @(negedge clk);
    start = v.hold_perm;
    a = 8'hA5; b = 8'h5A;
    #1;
    chk1({v.name, " perm wait_m"}, wait_req_m, 1'b1);
    chk1({v.name, " perm wait_l"}, wait_req_l, 1'b1);
    check_sr({v.name, " perm"}, 1'b1);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      start = 1'b1;
      #1;
      chk8($sformatf("%s unload%0d msb", v.name, n), result_m, v.exp_out[8*(15-n) +: 8]);
      chk8($sformatf("%s unload%0d lsb", v.name, n), result_l, v.exp_out[8*n +: 8]);
      chk1($sformatf("%s unload%0d wait", v.name, n), wait_req_m | wait_req_l, 1'b0);
      check_sr($sformatf("%s unload%0d", v.name, n), 1'b1);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check_sr({v.name, " idle after"}, 1'b0);
    chk8({v.name, " idle result"}, result_m, v.exp_out[7:0]);
  endtask

  initial begin
    vecs[0] = '{"zeros",  {16{8'h00}},             {16{8'h11}},                        1'b0};
    vecs[1] = '{"allDD",  {16{8'hDD}},             128'h0,                             1'b0};
    vecs[2] = '{"b0_0D",  {{15{8'hDD}}, 8'h0D},    (128'h01 << 96),                    1'b0};
    vecs[3] = '{"b0_DC",  {{15{8'hDD}}, 8'hDC},    (128'h04 << 64) | 128'h01,          1'b1};

    #12;
    chk1("reset wait", wait_req_m, 1'b0);
    chk8("reset result", result_m, 8'h00);
    check_sr("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Idle cycles with start low must change nothing.
    repeat (3) @(negedge clk);
    #1;
    check_sr("idle", 1'b0);
    chk8("idle result", result_l, 8'h00);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Abort: 3 loads of 0xFF, then reset mid-sequence.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'hFF;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check_sr("partial", 1'b1);
    // Result still shows byte 0 of the previous 0xDC vector.
    chk8("pre-reset result", result_m, 8'h01);
    rst = 1'b1;
    #1;
    chk1("async rst wait", wait_req_m, 1'b0);
    chk8("async rst result_m", result_m, 8'h00);
    chk8("async rst result_l", result_l, 8'h00);
    check_sr("async rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
